red_pitaya_guitar_gate: RTL

Noise gate placed directly upstream of the guitar amplification/overflow stage. It tracks the peak envelope of the incoming 16-bit signed ADC sample stream and opens, holds and closes a gain ramp with hysteresis. This suppresses pickup hum and hiss before the drive gain multiplies it. Output samples feed the amp's sound input with a fixed 2-cycle latency and a valid strobe.

---
 rtl/red_pitaya_guitar_pkg.sv | 21 ++
 rtl/red_pitaya_guitar_env.sv | 47 ++++
 rtl/red_pitaya_guitar_gate.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/red_pitaya_guitar_pkg.sv
// red_pitaya_guitar_pkg
// Shared constants for the guitar noise gate: gate state encodings, the
// unity gain value of the Q1.15 gain register, the magnitude saturation
// level, and a helper that floors a zero ramp step to one.
package red_pitaya_guitar_pkg;

  localparam logic [2:0] ST_CLOSED  = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [15:0] GAIN_UNITY = 16'h8000;
  localparam logic [15:0] MAG_SAT    = 16'h7FFF;

  // A zero step would stall the ramp forever, so it behaves as a step of one.
  function automatic logic [15:0] step_floor(input logic [15:0] step);
    return (step == 16'd0) ? 16'd1 : step;
  endfunction

endpackage

// File: rtl/red_pitaya_guitar_env.sv
// red_pitaya_guitar_env
// Peak envelope follower. Takes |sample| saturated to 0x7FFF, jumps up to
// any larger magnitude and otherwise decays by max(env >> ENV_SHIFT, 1).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   valid      : update strobe, envelope holds when low
//   sample     : signed input sample (DW up to 16)
//   env_next   : combinational envelope value this sample would produce
//   env        : registered envelope
module red_pitaya_guitar_env
  import red_pitaya_guitar_pkg::*;
#(
  parameter int DW        = 16,
  parameter int ENV_SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [DW-1:0] sample,
  output logic [15:0]   env_next,
  output logic [15:0]   env
);

  logic [DW-1:0] mag;
  logic [15:0]   mag16;
  logic [15:0]   mag_sat;
  logic [15:0]   decay;

  always_comb begin
    // Two's complement negation of the most negative value wraps back to
    // 0x8000 as an unsigned number, which the saturation below catches.
    mag     = sample[DW-1] ? ((~sample) + DW'(1)) : sample;
    mag16   = 16'(mag);
    mag_sat = (mag16 > MAG_SAT) ? MAG_SAT : mag16;
    decay   = env >> ENV_SHIFT;
    if (decay == 16'd0) decay = 16'd1;
    if (mag_sat >= env)   env_next = mag_sat;
    else if (env > decay) env_next = env - decay;
    else                  env_next = 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        env <= 16'd0;
    else if (valid) env <= env_next;
  end

endmodule

// File: rtl/red_pitaya_guitar_gate.sv
// red_pitaya_guitar_gate
// Noise gate ahead of the guitar amp stage. Envelope-driven FSM ramps a
// Q1.15 gain between 0 and unity with hysteresis and a hold period, and the
// gain multiplies the sample with a fixed two-cycle latency.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   in_sound_i/in_valid_i : signed input sample and its strobe
//   enable_i              : 0 bypasses the gate (unity gain)
//   open_thr_i/close_thr_i: envelope thresholds (close clipped to open)
//   hold_i                : samples to stay open after falling below close
//   attack_step_i/release_step_i : gain ramp steps per sample
//   out_sound_o/out_valid_o : gated sample and its strobe
//   env_o, state_o        : stage-1 envelope and gate state
module red_pitaya_guitar_gate
  import red_pitaya_guitar_pkg::*;
#(
  parameter int DW        = 16,
  parameter int ENV_SHIFT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] in_sound_i,
  input  logic          in_valid_i,
  input  logic          enable_i,
  input  logic [15:0]   open_thr_i,
  input  logic [15:0]   close_thr_i,
  input  logic [15:0]   hold_i,
  input  logic [15:0]   attack_step_i,
  input  logic [15:0]   release_step_i,
  output logic [DW-1:0] out_sound_o,
  output logic          out_valid_o,
  output logic [15:0]   env_o,
  output logic [2:0]    state_o
);

  logic [15:0]   env_next;
  logic [2:0]    state_q, state_d;
  logic [15:0]   gain_q, gain_d;
  logic [15:0]   hold_q, hold_d;
  logic [DW-1:0] x_q;
  logic          vld_q;

  logic [15:0] close_eff, a_step, r_step, gain_up, gain_dn;
  logic [16:0] up_sum;
  logic        above_open, below_close;

  logic signed [DW+17:0] g_ext, x_ext, prod;

  red_pitaya_guitar_env #(.DW(DW), .ENV_SHIFT(ENV_SHIFT)) u_env (
    .clk      (clk_i),
    .rst      (rst_i),
    .valid    (in_valid_i),
    .sample   (in_sound_i),
    .env_next (env_next),
    .env      (env_o)
  );

  // Gain follows the state being entered: entering ATTACK applies an attack
  // step, entering RELEASE applies a release step, in the same sample.
  always_comb begin
    close_eff   = (close_thr_i < open_thr_i) ? close_thr_i : open_thr_i;
    a_step      = step_floor(attack_step_i);
    r_step      = step_floor(release_step_i);
    up_sum      = {1'b0, gain_q} + {1'b0, a_step};
    gain_up     = (up_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : up_sum[15:0];
    gain_dn     = (gain_q > r_step) ? (gain_q - r_step) : 16'd0;
    above_open  = (env_next >= open_thr_i);
    below_close = (env_next < close_eff);

    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    if (!enable_i) begin
      state_d = ST_OPEN;
      gain_d  = GAIN_UNITY;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          gain_d = 16'd0;
          if (above_open) begin
            state_d = ST_ATTACK;
            gain_d  = gain_up;
          end
        end
        ST_ATTACK: begin
          if (below_close) begin
            state_d = ST_RELEASE;
            gain_d  = gain_dn;
          end else begin
            gain_d = gain_up;
            if (gain_up == GAIN_UNITY) state_d = ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (below_close) begin
            state_d = ST_HOLD;
            hold_d  = hold_i;
          end
        end
        ST_HOLD: begin
          if (above_open) begin
            state_d = ST_OPEN;
          end else if (hold_q == 16'd0) begin
            state_d = ST_RELEASE;
            gain_d  = gain_dn;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
        ST_RELEASE: begin
          if (above_open) begin
            state_d = ST_ATTACK;
            gain_d  = gain_up;
          end else begin
            gain_d = gain_dn;
            if (gain_dn == 16'd0) state_d = ST_CLOSED;
          end
        end
        default: begin
          state_d = ST_CLOSED;
          gain_d  = 16'd0;
        end
      endcase
    end
  end

  // Gain is zero-extended (always non-negative), sample sign-extended; with
  // gain at 0x8000 the shift returns the sample unchanged, even -32768.
  always_comb begin
    g_ext = {{(DW+2){1'b0}}, gain_q};
    x_ext = {{18{x_q[DW-1]}}, x_q};
    prod  = g_ext * x_ext;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_CLOSED;
      gain_q      <= 16'd0;
      hold_q      <= 16'd0;
      x_q         <= '0;
      vld_q       <= 1'b0;
      out_sound_o <= '0;
      out_valid_o <= 1'b0;
    end else begin
      vld_q       <= in_valid_i;
      out_valid_o <= vld_q;
      if (vld_q) out_sound_o <= prod[DW+14:15];
      if (in_valid_i) begin
        x_q     <= in_sound_i;
        state_q <= state_d;
        gain_q  <= gain_d;
        hold_q  <= hold_d;
      end
    end
  end

  assign state_o = state_q;

endmodule
